// File: rtl/corevx_dbus_responder_pkg.sv
// Shared encodings for the execute-stage data-cache command interface and
// the uncached responder state machine.
package corevx_dbus_responder_pkg;

   localparam logic [3:0] CACHE_CMD_NONE      = 4'd0;
   localparam logic [3:0] CACHE_CMD_LOAD      = 4'd1;
   localparam logic [3:0] CACHE_CMD_STORE     = 4'd2;
   localparam logic [3:0] CACHE_CMD_FLUSH_ALL = 4'd3;

   localparam logic [3:0] CACHE_RESPONSE_IDLE        = 4'd0;
   localparam logic [3:0] CACHE_RESPONSE_WAIT        = 4'd1;
   localparam logic [3:0] CACHE_RESPONSE_DONE        = 4'd2;
   localparam logic [3:0] CACHE_RESPONSE_MISSALIGNED = 4'd3;
   localparam logic [3:0] CACHE_RESPONSE_ACCESSFAULT = 4'd4;
   localparam logic [3:0] CACHE_RESPONSE_PAGEFAULT   = 4'd5;

   localparam logic [2:0] LOAD_LB  = 3'b000;
   localparam logic [2:0] LOAD_LH  = 3'b001;
   localparam logic [2:0] LOAD_LW  = 3'b010;
   localparam logic [2:0] LOAD_LBU = 3'b100;
   localparam logic [2:0] LOAD_LHU = 3'b101;

   localparam logic [1:0] STORE_SB = 2'b00;
   localparam logic [1:0] STORE_SH = 2'b01;
   localparam logic [1:0] STORE_SW = 2'b10;

   typedef enum logic [2:0] {
      ST_INIT  = 3'd0,
      ST_IDLE  = 3'd1,
      ST_CHECK = 3'd2,
      ST_REQ   = 3'd3,
      ST_RESP  = 3'd4
   } state_e;

   // Access width in bytes for a load/store type; 0 marks an illegal encoding.
   function automatic logic [2:0] access_bytes(input logic is_load, input logic [2:0] load_type,
                                                input logic [1:0] store_type);
      logic [2:0] w_bytes;
      w_bytes = 3'd0;
      if (is_load) begin
         case (load_type)
            LOAD_LB, LOAD_LBU: w_bytes = 3'd1;
            LOAD_LH, LOAD_LHU: w_bytes = 3'd2;
            LOAD_LW:           w_bytes = 3'd4;
            default:           w_bytes = 3'd0;
         endcase
      end else begin
         case (store_type)
            STORE_SB: w_bytes = 3'd1;
            STORE_SH: w_bytes = 3'd2;
            STORE_SW: w_bytes = 3'd4;
            default:  w_bytes = 3'd0;
         endcase
      end
      return w_bytes;
   endfunction

endpackage

// File: rtl/corevx_dbus_responder_loadgen.sv
// Load result generation: pick the addressed byte/half out of the bus word
// and sign- or zero-extend it. Purely combinational.
module corevx_loadgen
   import corevx_dbus_responder_pkg::*;
(
   input  logic [31:0] i_rdata,
   input  logic [1:0]  i_offset,
   input  logic [2:0]  i_load_type,
   output logic [31:0] o_data
);

   logic [31:0] w_shifted;

   assign w_shifted = i_rdata >> {i_offset, 3'b000};

   always_comb begin
      o_data = w_shifted;
      case (i_load_type)
         LOAD_LB:  o_data = {{24{w_shifted[7]}}, w_shifted[7:0]};
         LOAD_LH:  o_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
         LOAD_LBU: o_data = {24'd0, w_shifted[7:0]};
         LOAD_LHU: o_data = {16'd0, w_shifted[15:0]};
         default:  o_data = w_shifted;
      endcase
   end

endmodule

// File: rtl/corevx_dbus_responder.sv
// Uncached responder for the execute-stage data-cache interface: validates a
// LOAD/STORE, runs one single-beat bus transaction and returns a completion code.
module corevx_dbus_responder
   import corevx_dbus_responder_pkg::*;
#(
   parameter logic [31:0] MEM_BASE    = 32'h0000_0000,
   parameter logic [31:0] MEM_SIZE    = 32'h0001_0000,
   parameter int          INIT_CYCLES = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [3:0]  c_cmd,
   input  logic [31:0] c_address,
   input  logic [2:0]  c_load_type,
   input  logic [1:0]  c_store_type,
   input  logic [31:0] c_store_data,
   output logic [3:0]  c_response,
   output logic [31:0] c_load_data,
   output logic        c_reset_done,
   output logic        m_valid,
   input  logic        m_ready,
   output logic        m_write,
   output logic [31:0] m_addr,
   output logic [31:0] m_wdata,
   output logic [3:0]  m_wstrb,
   input  logic        m_rvalid,
   input  logic        m_rerror,
   input  logic [31:0] m_rdata
);

   localparam int CNT_W = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(INIT_CYCLES - 1);

   state_e           r_state, w_state_next;
   logic [CNT_W-1:0] r_init_cnt, w_init_cnt_next;
   logic [3:0]       r_cmd, w_cmd_next;
   logic [31:0]      r_addr, w_addr_next;
   logic [2:0]       r_load_type, w_load_type_next;
   logic [1:0]       r_store_type, w_store_type_next;
   logic [31:0]      r_store_data, w_store_data_next;
   logic [3:0]       r_response, w_response_next;
   logic [31:0]      r_load_data, w_load_data_next;
   logic             r_m_valid, w_m_valid_next;
   logic             r_m_write, w_m_write_next;
   logic [31:0]      r_m_addr, w_m_addr_next;
   logic [31:0]      r_m_wdata, w_m_wdata_next;
   logic [3:0]       r_m_wstrb, w_m_wstrb_next;

   logic        w_is_load;
   logic [2:0]  w_bytes;
   logic        w_misaligned;
   logic        w_in_range;
   logic [31:0] w_load_ext;
   logic [3:0]  w_st_strb;
   logic [31:0] w_st_data;

   assign w_is_load = (r_cmd == CACHE_CMD_LOAD);
   assign w_bytes   = access_bytes(w_is_load, r_load_type, r_store_type);

   // Illegal width encodings report as misaligned, the same as a bad offset.
   assign w_misaligned = (w_bytes == 3'd0) ||
                         ((w_bytes == 3'd2) && r_addr[0]) ||
                         ((w_bytes == 3'd4) && (r_addr[1:0] != 2'b00));

   // 33-bit compare so a window ending at 4 GiB does not wrap.
   assign w_in_range = (r_addr >= MEM_BASE) &&
                       ({1'b0, r_addr} < ({1'b0, MEM_BASE} + {1'b0, MEM_SIZE}));

   always_comb begin
      w_st_strb = 4'b1111;
      w_st_data = r_store_data;
      case (r_store_type)
         STORE_SB: begin
            w_st_strb = 4'b0001 << r_addr[1:0];
            w_st_data = {4{r_store_data[7:0]}};
         end
         STORE_SH: begin
            w_st_strb = 4'b0011 << r_addr[1:0];
            w_st_data = {2{r_store_data[15:0]}};
         end
         default: begin
            w_st_strb = 4'b1111;
            w_st_data = r_store_data;
         end
      endcase
   end

   corevx_loadgen u_loadgen (
      .i_rdata     (m_rdata),
      .i_offset    (r_addr[1:0]),
      .i_load_type (r_load_type),
      .o_data      (w_load_ext)
   );

   always_comb begin
      w_state_next      = r_state;
      w_init_cnt_next   = r_init_cnt;
      w_cmd_next        = r_cmd;
      w_addr_next       = r_addr;
      w_load_type_next  = r_load_type;
      w_store_type_next = r_store_type;
      w_store_data_next = r_store_data;
      w_response_next   = r_response;
      w_load_data_next  = r_load_data;
      w_m_valid_next    = r_m_valid;
      w_m_write_next    = r_m_write;
      w_m_addr_next     = r_m_addr;
      w_m_wdata_next    = r_m_wdata;
      w_m_wstrb_next    = r_m_wstrb;

      case (r_state)
         ST_INIT: begin
            w_init_cnt_next = r_init_cnt + 1'b1;
            if (r_init_cnt == CNT_LAST) w_state_next = ST_IDLE;
         end
         ST_IDLE: begin
            w_response_next = CACHE_RESPONSE_IDLE;
            if ((c_cmd == CACHE_CMD_LOAD) || (c_cmd == CACHE_CMD_STORE) ||
                (c_cmd == CACHE_CMD_FLUSH_ALL)) begin
               w_cmd_next        = c_cmd;
               w_addr_next       = c_address;
               w_load_type_next  = c_load_type;
               w_store_type_next = c_store_type;
               w_store_data_next = c_store_data;
               w_response_next   = CACHE_RESPONSE_WAIT;
               w_state_next      = ST_CHECK;
            end
         end
         ST_CHECK: begin
            w_state_next = ST_IDLE;
            if (r_cmd == CACHE_CMD_FLUSH_ALL) begin
               w_response_next = CACHE_RESPONSE_DONE;
            end else if (w_misaligned) begin
               w_response_next = CACHE_RESPONSE_MISSALIGNED;
            end else if (!w_in_range) begin
               w_response_next = CACHE_RESPONSE_ACCESSFAULT;
            end else begin
               w_state_next   = ST_REQ;
               w_m_valid_next = 1'b1;
               w_m_write_next = !w_is_load;
               w_m_addr_next  = {r_addr[31:2], 2'b00};
               w_m_wdata_next = w_is_load ? 32'd0 : w_st_data;
               w_m_wstrb_next = w_is_load ? 4'd0 : w_st_strb;
            end
         end
         ST_REQ: begin
            if (m_ready) begin
               w_m_valid_next = 1'b0;
               w_state_next   = ST_RESP;
            end
         end
         ST_RESP: begin
            if (m_rvalid) begin
               w_state_next = ST_IDLE;
               if (m_rerror) begin
                  w_response_next = CACHE_RESPONSE_ACCESSFAULT;
               end else begin
                  w_response_next = CACHE_RESPONSE_DONE;
                  if (w_is_load) w_load_data_next = w_load_ext;
               end
            end
         end
         default: w_state_next = ST_INIT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state      <= ST_INIT;
         r_init_cnt   <= '0;
         r_cmd        <= CACHE_CMD_NONE;
         r_addr       <= '0;
         r_load_type  <= '0;
         r_store_type <= '0;
         r_store_data <= '0;
         r_response   <= CACHE_RESPONSE_IDLE;
         r_load_data  <= '0;
         r_m_valid    <= 1'b0;
         r_m_write    <= 1'b0;
         r_m_addr     <= '0;
         r_m_wdata    <= '0;
         r_m_wstrb    <= '0;
      end else begin
         r_state      <= w_state_next;
         r_init_cnt   <= w_init_cnt_next;
         r_cmd        <= w_cmd_next;
         r_addr       <= w_addr_next;
         r_load_type  <= w_load_type_next;
         r_store_type <= w_store_type_next;
         r_store_data <= w_store_data_next;
         r_response   <= w_response_next;
         r_load_data  <= w_load_data_next;
         r_m_valid    <= w_m_valid_next;
         r_m_write    <= w_m_write_next;
         r_m_addr     <= w_m_addr_next;
         r_m_wdata    <= w_m_wdata_next;
         r_m_wstrb    <= w_m_wstrb_next;
      end
   end

   assign c_response   = r_response;
   assign c_load_data  = r_load_data;
   assign c_reset_done = (r_state != ST_INIT);
   assign m_valid      = r_m_valid;
   assign m_write      = r_m_write;
   assign m_addr       = r_m_addr;
   assign m_wdata      = r_m_wdata;
   assign m_wstrb      = r_m_wstrb;

endmodule

// File: tb/tb_corevx_dbus_responder.sv
// Directed bench for corevx_dbus_responder: the bench plays execute and the
// memory bus, all driven and sampled on the falling clock edge.
module tb_corevx_dbus_responder;

   localparam logic [3:0] CMD_NONE  = 4'd0;
   localparam logic [3:0] CMD_LOAD  = 4'd1;
   localparam logic [3:0] CMD_STORE = 4'd2;
   localparam logic [3:0] CMD_FLUSH = 4'd3;

   localparam logic [31:0] R_IDLE  = 32'd0;
   localparam logic [31:0] R_WAIT  = 32'd1;
   localparam logic [31:0] R_DONE  = 32'd2;
   localparam logic [31:0] R_MISAL = 32'd3;
   localparam logic [31:0] R_AFLT  = 32'd4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  c_cmd;
   logic [31:0] c_address;
   logic [2:0]  c_load_type;
   logic [1:0]  c_store_type;
   logic [31:0] c_store_data;
   logic [3:0]  c_response;
   logic [31:0] c_load_data;
   logic        c_reset_done;
   logic        m_valid;
   logic        m_ready;
   logic        m_write;
   logic [31:0] m_addr;
   logic [31:0] m_wdata;
   logic [3:0]  m_wstrb;
   logic        m_rvalid;
   logic        m_rerror;
   logic [31:0] m_rdata;

   int n_assert = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   corevx_dbus_responder dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .c_cmd        (c_cmd),
      .c_address    (c_address),
      .c_load_type  (c_load_type),
      .c_store_type (c_store_type),
      .c_store_data (c_store_data),
      .c_response   (c_response),
      .c_load_data  (c_load_data),
      .c_reset_done (c_reset_done),
      .m_valid      (m_valid),
      .m_ready      (m_ready),
      .m_write      (m_write),
      .m_addr       (m_addr),
      .m_wdata      (m_wdata),
      .m_wstrb      (m_wstrb),
      .m_rvalid     (m_rvalid),
      .m_rerror     (m_rerror),
      .m_rdata      (m_rdata)
   );

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Presents a command for one cycle; returns at T+1 (CHECK cycle).
   task automatic issue(input logic [3:0] cmd, input logic [31:0] addr, input logic [2:0] lt,
                        input logic [1:0] st, input logic [31:0] d);
      c_cmd        = cmd;
      c_address    = addr;
      c_load_type  = lt;
      c_store_type = st;
      c_store_data = d;
      chk("pre_cmd_idle", {28'd0, c_response}, R_IDLE);
      tick();
      c_cmd = CMD_NONE;
      chk("check_wait", {28'd0, c_response}, R_WAIT);
      chk("check_no_valid", {31'd0, m_valid}, 32'd0);
   endtask

   // Early completion (error or flush): response at T+2, bus untouched.
   task automatic expect_quick(input string tag, input logic [31:0] code);
      tick();
      chk({tag, "_resp"}, {28'd0, c_response}, code);
      chk({tag, "_no_valid"}, {31'd0, m_valid}, 32'd0);
      tick();
      chk({tag, "_back_idle"}, {28'd0, c_response}, R_IDLE);
   endtask

   // Entered at T+2 with the request expected on the bus; returns at the
   // completion cycle.
   task automatic bus_txn(input string tag, input logic [31:0] e_addr, input logic e_write,
                          input logic [31:0] e_wdata, input logic [3:0] e_wstrb,
                          input int ready_delay, input logic [31:0] rdata, input logic rerr);
      for (int i = 0; i <= ready_delay; i++) begin
         chk({tag, "_m_valid"}, {31'd0, m_valid}, 32'd1);
         chk({tag, "_m_addr"}, m_addr, e_addr);
         chk({tag, "_m_write"}, {31'd0, m_write}, {31'd0, e_write});
         if (e_write) begin
            chk({tag, "_m_wdata"}, m_wdata, e_wdata);
            chk({tag, "_m_wstrb"}, {28'd0, m_wstrb}, {28'd0, e_wstrb});
         end
         chk({tag, "_req_wait"}, {28'd0, c_response}, R_WAIT);
         if (i == ready_delay) m_ready = 1'b1;
         tick();
      end
      m_ready = 1'b0;
      chk({tag, "_valid_drop"}, {31'd0, m_valid}, 32'd0);
      chk({tag, "_resp_wait"}, {28'd0, c_response}, R_WAIT);
      m_rvalid = 1'b1;
      m_rerror = rerr;
      m_rdata  = rdata;
      tick();
      m_rvalid = 1'b0;
      m_rerror = 1'b0;
      m_rdata  = 32'hDEAD_BEEF;
   endtask

   initial begin
      rst_n        = 1'b0;
      c_cmd        = CMD_NONE;
      c_address    = 32'd0;
      c_load_type  = 3'b000;
      c_store_type = 2'b00;
      c_store_data = 32'd0;
      m_ready      = 1'b0;
      m_rvalid     = 1'b0;
      m_rerror     = 1'b0;
      m_rdata      = 32'd0;
      repeat (3) tick();

      chk("rst_response", {28'd0, c_response}, R_IDLE);
      chk("rst_load_data", c_load_data, 32'd0);
      chk("rst_reset_done", {31'd0, c_reset_done}, 32'd0);
      chk("rst_m_valid", {31'd0, m_valid}, 32'd0);
      chk("rst_m_write", {31'd0, m_write}, 32'd0);
      chk("rst_m_addr", m_addr, 32'd0);
      chk("rst_m_wdata", m_wdata, 32'd0);
      chk("rst_m_wstrb", {28'd0, m_wstrb}, 32'd0);

      // Release reset with a LOAD pending: it must be ignored during init.
      rst_n       = 1'b1;
      c_cmd       = CMD_LOAD;
      c_address   = 32'h0000_0100;
      c_load_type = 3'b010;
      for (int i = 0; i < 16; i++) begin
         chk("init_not_done", {31'd0, c_reset_done}, 32'd0);
         chk("init_no_valid", {31'd0, m_valid}, 32'd0);
         if (i == 8) c_cmd = CMD_NONE;
         tick();
      end
      chk("init_done", {31'd0, c_reset_done}, 32'd1);
      chk("init_resp_idle", {28'd0, c_response}, R_IDLE);
      tick();
      chk("after_init_no_valid", {31'd0, m_valid}, 32'd0);
      chk("after_init_resp", {28'd0, c_response}, R_IDLE);

      // LB 0x103: byte 3 of 0x80FF_0000 = 0x80, sign-extended.
      issue(CMD_LOAD, 32'h0000_0103, 3'b000, 2'b00, 32'd0);
      tick();
      bus_txn("lb", 32'h0000_0100, 1'b0, 32'd0, 4'd0, 0, 32'h80FF_0000, 1'b0);
      chk("lb_done", {28'd0, c_response}, R_DONE);
      chk("lb_data", c_load_data, 32'hFFFF_FF80);
      tick();
      chk("lb_idle", {28'd0, c_response}, R_IDLE);

      issue(CMD_LOAD, 32'h0000_0103, 3'b100, 2'b00, 32'd0);
      tick();
      bus_txn("lbu", 32'h0000_0100, 1'b0, 32'd0, 4'd0, 0, 32'h80FF_0000, 1'b0);
      chk("lbu_done", {28'd0, c_response}, R_DONE);
      chk("lbu_data", c_load_data, 32'h0000_0080);
      tick();
      chk("lbu_idle", {28'd0, c_response}, R_IDLE);

      // SH 0x202: upper half lanes, data replicated.
      issue(CMD_STORE, 32'h0000_0202, 3'b000, 2'b01, 32'h1234_ABCD);
      tick();
      bus_txn("sh", 32'h0000_0200, 1'b1, 32'hABCD_ABCD, 4'b1100, 0, 32'h0, 1'b0);
      chk("sh_done", {28'd0, c_response}, R_DONE);
      chk("sh_keeps_load", c_load_data, 32'h0000_0080);
      tick();
      chk("sh_idle", {28'd0, c_response}, R_IDLE);

      issue(CMD_STORE, 32'h0000_0301, 3'b000, 2'b00, 32'h0000_00A5);
      tick();
      bus_txn("sb", 32'h0000_0300, 1'b1, 32'hA5A5_A5A5, 4'b0010, 0, 32'h0, 1'b0);
      chk("sb_done", {28'd0, c_response}, R_DONE);
      tick();

      issue(CMD_STORE, 32'h0000_0FFC, 3'b000, 2'b10, 32'hCAFE_F00D);
      tick();
      bus_txn("sw", 32'h0000_0FFC, 1'b1, 32'hCAFE_F00D, 4'b1111, 0, 32'h0, 1'b0);
      chk("sw_done", {28'd0, c_response}, R_DONE);
      tick();

      // Error paths complete at T+2 without touching the bus.
      issue(CMD_LOAD, 32'h0000_0101, 3'b010, 2'b00, 32'd0);
      expect_quick("lw_misal", R_MISAL);
      issue(CMD_STORE, 32'h0001_0000, 3'b000, 2'b10, 32'h1111_1111);
      expect_quick("sw_range", R_AFLT);
      issue(CMD_LOAD, 32'h0000_0100, 3'b011, 2'b00, 32'd0);
      expect_quick("ld_type011", R_MISAL);
      issue(CMD_STORE, 32'h0000_0100, 3'b000, 2'b11, 32'd0);
      expect_quick("st_type11", R_MISAL);
      issue(CMD_LOAD, 32'h0000_0121, 3'b101, 2'b00, 32'd0);
      expect_quick("lhu_misal", R_MISAL);
      issue(CMD_LOAD, 32'h0000_FFFF, 3'b000, 2'b00, 32'd0);
      tick();
      bus_txn("lb_top", 32'h0000_FFFC, 1'b0, 32'd0, 4'd0, 0, 32'h7F00_0000, 1'b0);
      chk("lb_top_data", c_load_data, 32'h0000_007F);
      tick();

      // Stalled request then bus error: m_* held, load data untouched.
      issue(CMD_LOAD, 32'h0000_0010, 3'b010, 2'b00, 32'd0);
      tick();
      bus_txn("lw_err", 32'h0000_0010, 1'b0, 32'd0, 4'd0, 5, 32'h5555_5555, 1'b1);
      chk("lw_err_resp", {28'd0, c_response}, R_AFLT);
      chk("lw_err_keeps_load", c_load_data, 32'h0000_007F);
      tick();
      chk("lw_err_idle", {28'd0, c_response}, R_IDLE);

      issue(CMD_LOAD, 32'h0000_0022, 3'b101, 2'b00, 32'd0);
      tick();
      bus_txn("lhu", 32'h0000_0020, 1'b0, 32'd0, 4'd0, 1, 32'hBEEF_1234, 1'b0);
      chk("lhu_data", c_load_data, 32'h0000_BEEF);
      tick();
      issue(CMD_LOAD, 32'h0000_0022, 3'b001, 2'b00, 32'd0);
      tick();
      bus_txn("lh", 32'h0000_0020, 1'b0, 32'd0, 4'd0, 0, 32'hBEEF_1234, 1'b0);
      chk("lh_data", c_load_data, 32'hFFFF_BEEF);
      tick();
      issue(CMD_LOAD, 32'h0000_0040, 3'b010, 2'b00, 32'd0);
      tick();
      bus_txn("lw", 32'h0000_0040, 1'b0, 32'd0, 4'd0, 0, 32'h1234_5678, 1'b0);
      chk("lw_data", c_load_data, 32'h1234_5678);
      tick();

      issue(CMD_FLUSH, 32'h0000_0000, 3'b000, 2'b00, 32'd0);
      expect_quick("flush", R_DONE);

      // Reset asserted while the request is on the bus.
      issue(CMD_LOAD, 32'h0000_0044, 3'b010, 2'b00, 32'd0);
      tick();
      chk("rreq_valid", {31'd0, m_valid}, 32'd1);
      rst_n = 1'b0;
      tick();
      chk("rreq_valid_drop", {31'd0, m_valid}, 32'd0);
      chk("rreq_resp_idle", {28'd0, c_response}, R_IDLE);
      chk("rreq_not_done", {31'd0, c_reset_done}, 32'd0);
      chk("rreq_load_clr", c_load_data, 32'd0);
      rst_n = 1'b1;
      repeat (16) tick();
      chk("rreq_redone", {31'd0, c_reset_done}, 32'd1);
      chk("rreq_still_idle", {31'd0, m_valid}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
